// File: rtl/agc_shift_ctrl.sv
// agc_shift_ctrl: per-frame automatic gain control picking the 32->16 bit output shift from the frame peak.
// Optional build macro AGC_MANUAL_OVERRIDE_EN adds the manual_en/manual_shift override ports.
module agc_shift_ctrl #(
    parameter int unsigned HEADROOM    = 1,
    parameter int unsigned HOLD_FRAMES = 4,
    parameter int unsigned INIT_SHIFT  = 8,
    parameter int unsigned MAX_SHIFT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ms_in,
    input  logic [31:0] max_in,
`ifdef AGC_MANUAL_OVERRIDE_EN
    input  logic        manual_en,
    input  logic [4:0]  manual_shift,
`endif
    output logic [15:0] scaled_coeff,
    output logic        clip_flag,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [4:0]       SHIFT_INIT = 5'(INIT_SHIFT);
    localparam logic [4:0]       SHIFT_MAX  = 5'(MAX_SHIFT);
    localparam logic [5:0]       ZERO_PEAK  = 6'd63;
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_ENCODE,
        S_DECIDE,
        S_WAIT
    } state_t;

    state_t           state;
    logic [4:0]       shift_cur;
    logic [4:0]       shift_tgt;
    logic [31:0]      max_r;
    logic [5:0]       p_r;
    logic [4:0]       desired_r;
    logic [CNT_W-1:0] dec_cnt;

    // Leading-one index of the peak, 63 flags an all-zero peak.
    function automatic logic [5:0] leading_one(input logic [31:0] v);
        logic [5:0] idx;
        idx = ZERO_PEAK;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = 6'(i);
        end
        return idx;
    endfunction

    function automatic logic [4:0] desired_shift(input logic [5:0] p);
        logic signed [6:0] d;
        d = $signed({1'b0, p}) + $signed(7'(HEADROOM)) - 7'sd14;
        if (p == ZERO_PEAK)                 return 5'd0;
        if (d < 7'sd0)                      return 5'd0;
        if (d > $signed(7'(MAX_SHIFT)))     return SHIFT_MAX;
        return d[4:0];
    endfunction

    // The peak clips when it reaches bit (shift + 15), the sign bit of the selected 16-bit window.
    logic [5:0] clip_bit;
    logic       clip_hit;

    assign clip_bit = {1'b0, shift_cur} + 6'd15;
    assign clip_hit = |(max_in >> clip_bit);

    logic       manual_active;
    logic [4:0] apply_shift;

`ifdef AGC_MANUAL_OVERRIDE_EN
    logic [4:0] manual_clamped;

    assign manual_clamped = (manual_shift > SHIFT_MAX) ? SHIFT_MAX : manual_shift;
    assign manual_active  = manual_en;
    assign apply_shift    = manual_en ? manual_clamped : shift_tgt;
`else
    assign manual_active  = 1'b0;
    assign apply_shift    = shift_tgt;
`endif

    assign scaled_coeff = {11'b0, shift_cur};

    // NOTE: every register here is assigned with <= so all updates in a clock edge see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            shift_cur <= SHIFT_INIT;
            shift_tgt <= SHIFT_INIT;
            max_r     <= '0;
            p_r       <= ZERO_PEAK;
            desired_r <= '0;
            dec_cnt   <= '0;
            clip_flag <= 1'b0;
            busy      <= 1'b0;
        end else if (ms_in) begin
            // A frame boundary always wins: apply the target and abandon any decision in flight.
            shift_cur <= apply_shift;
            max_r     <= max_in;
            clip_flag <= clip_hit;
            busy      <= 1'b1;
            state     <= S_CAPTURE;
            if (manual_active) begin
                shift_tgt <= apply_shift;
                dec_cnt   <= '0;
            end
        end else begin
            clip_flag <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                end
                S_CAPTURE: begin
                    p_r   <= leading_one(max_r);
                    state <= S_ENCODE;
                end
                S_ENCODE: begin
                    desired_r <= desired_shift(p_r);
                    state     <= S_DECIDE;
                end
                S_DECIDE: begin
                    busy  <= 1'b0;
                    state <= S_WAIT;
                    if (!manual_active) begin
                        if (desired_r > shift_tgt) begin
                            shift_tgt <= desired_r;
                            dec_cnt   <= '0;
                        end else if (desired_r == shift_tgt) begin
                            dec_cnt <= '0;
                        end else if (dec_cnt == HOLD_LAST) begin
                            shift_tgt <= shift_tgt - 5'd1;
                            dec_cnt   <= '0;
                        end else begin
                            dec_cnt <= dec_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_agc_shift_ctrl.sv
// Self-checking bench for agc_shift_ctrl: directed table, multi-cycle corner sequences and a randomized frame-level model.
module tb_agc_shift_ctrl;

    localparam int HEADROOM    = 1;
    localparam int HOLD_FRAMES = 4;
    localparam int INIT_SHIFT  = 8;
    localparam int MAX_SHIFT   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ms_in = 1'b0;
    logic [31:0] max_in = '0;
    logic [15:0] scaled_coeff;
    logic        clip_flag;
    logic        busy;
`ifdef AGC_MANUAL_OVERRIDE_EN
    logic        manual_en = 1'b0;
    logic [4:0]  manual_shift = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level reference state: applied shift, decided target, consecutive lower requests.
    int m_cur;
    int m_tgt;
    int m_run;

    typedef struct {
        logic [31:0] peak;
        int          len;
        logic [4:0]  exp_coeff;
        logic        exp_clip;
    } vec_t;

    vec_t vecs[18];

    agc_shift_ctrl #(
        .HEADROOM    (HEADROOM),
        .HOLD_FRAMES (HOLD_FRAMES),
        .INIT_SHIFT  (INIT_SHIFT),
        .MAX_SHIFT   (MAX_SHIFT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ms_in        (ms_in),
        .max_in       (max_in),
`ifdef AGC_MANUAL_OVERRIDE_EN
        .manual_en    (manual_en),
        .manual_shift (manual_shift),
`endif
        .scaled_coeff (scaled_coeff),
        .clip_flag    (clip_flag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int desired_of(input logic [31:0] peak);
        int p;
        int d;
        if (peak == 32'd0) return 0;
        p = 0;
        while ((64'd1 << (p + 1)) <= 64'(peak)) p++;
        d = p + HEADROOM - 14;
        if (d < 0) return 0;
        if (d > MAX_SHIFT) return MAX_SHIFT;
        return d;
    endfunction

    task automatic model_decide(input int d);
        if (d > m_tgt) begin
            m_tgt = d;
            m_run = 0;
        end else if (d == m_tgt) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == HOLD_FRAMES) begin
                m_tgt--;
                m_run = 0;
            end
        end
    endtask

    // Called at a falling edge; drives one frame of 'len' cycles whose boundary pulse carries 'peak'.
    task automatic run_frame(input logic [31:0] peak, input int len, input logic [4:0] exp_coeff,
                             input logic exp_clip, input string tag);
        ms_in  = 1'b1;
        max_in = peak;
        @(negedge clk);
        ms_in  = 1'b0;
        max_in = $urandom;
        check({tag, " coeff"}, 32'(scaled_coeff), 32'(exp_coeff));
        check({tag, " clip"},  32'(clip_flag),    32'(exp_clip));
        check({tag, " busy1"}, 32'(busy),         32'd1);
        for (int i = 0; i < len - 1; i++) begin
            @(negedge clk);
            if (i == 1) check({tag, " busy3"}, 32'(busy), 32'd1);
            if (i == 2) check({tag, " idle4"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic model_frame(input logic [31:0] peak, input int len, input string tag);
        logic exp_clip;
        exp_clip = (64'(peak) >= (64'd1 << (m_cur + 15)));
        m_cur    = m_tgt;
        run_frame(peak, len, 5'(m_cur), exp_clip, tag);
        if (len >= 4) model_decide(desired_of(peak));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        ms_in = 1'b0;
        #1;
        check("rst coeff", 32'(scaled_coeff), 32'(INIT_SHIFT));
        check("rst clip",  32'(clip_flag),    32'd0);
        check("rst busy",  32'(busy),         32'd0);
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        m_cur = INIT_SHIFT;
        m_tgt = INIT_SHIFT;
        m_run = 0;
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{32'h0010_0000, 8,  5'd8,  1'b0};
        vecs[1]  = '{32'h0010_0000, 6,  5'd8,  1'b0};
        vecs[2]  = '{32'h0010_0000, 8,  5'd8,  1'b0};
        vecs[3]  = '{32'h0010_0000, 4,  5'd8,  1'b0};
        vecs[4]  = '{32'h0010_0000, 8,  5'd7,  1'b0};
        vecs[5]  = '{32'h0020_0000, 8,  5'd7,  1'b0};
        vecs[6]  = '{32'h0010_0000, 8,  5'd8,  1'b0};
        vecs[7]  = '{32'h0020_0000, 8,  5'd8,  1'b0};
        vecs[8]  = '{32'h0010_0000, 8,  5'd8,  1'b0};
        vecs[9]  = '{32'h0010_0000, 5,  5'd8,  1'b0};
        vecs[10] = '{32'h0010_0000, 8,  5'd8,  1'b0};
        vecs[11] = '{32'h0010_0000, 8,  5'd8,  1'b0};
        vecs[12] = '{32'h0040_0000, 8,  5'd7,  1'b0};
        vecs[13] = '{32'h4000_0000, 8,  5'd9,  1'b1};
        vecs[14] = '{32'hFFFF_FFFF, 8,  5'd16, 1'b1};
        vecs[15] = '{32'hFFFF_FFFF, 10, 5'd16, 1'b1};
        vecs[16] = '{32'h7FFF_FFFF, 8,  5'd16, 1'b0};
        vecs[17] = '{32'h8000_0000, 8,  5'd16, 1'b1};

        // Reset, then idle mid-frame with no boundary: shift must stay at its reset value.
        do_reset();
        repeat (20) @(negedge clk);
        check("idle coeff", 32'(scaled_coeff), 32'(INIT_SHIFT));
        check("idle busy",  32'(busy),         32'd0);
        run_frame(32'h0040_0000, 64, 5'd8, 1'b0, "rst_f1");
        run_frame(32'h0040_0000, 64, 5'd9, 1'b0, "rst_f2");

        // Directed table: hysteresis, a counter-clearing frame, fast increase and clip thresholds.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            run_frame(vecs[i].peak, vecs[i].len, vecs[i].exp_coeff, vecs[i].exp_clip, $sformatf("vec%0d", i));
        end

        // Zero peaks step the shift down once per HOLD_FRAMES frames until it rests at 0.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            int e;
            e = INIT_SHIFT - n / HOLD_FRAMES;
            if (e < 0) e = 0;
            run_frame(32'd0, 4, 5'(e), 1'b0, $sformatf("zero%0d", n));
        end
        run_frame(32'hFFFF_FFFF, 8, 5'd0,  1'b1, "clamp0");
        run_frame(32'hFFFF_FFFF, 8, 5'd16, 1'b1, "clamp1");
        run_frame(32'hFFFF_FFFF, 8, 5'd16, 1'b1, "clamp2");

        // Short frame: a boundary two cycles after the last one abandons the pending jump to 16.
        do_reset();
        run_frame(32'h4000_0000, 2, 5'd8, 1'b1, "short_a");
        run_frame(32'd0,         8, 5'd8, 1'b0, "short_b");
        run_frame(32'd0,         8, 5'd8, 1'b0, "short_c");

        // Asynchronous reset while a decision sits in DECIDE.
        do_reset();
        run_frame(32'h4000_0000, 8, 5'd8, 1'b1, "ar_a");
        ms_in  = 1'b1;
        max_in = 32'h4000_0000;
        @(negedge clk);
        ms_in = 1'b0;
        check("ar coeff16", 32'(scaled_coeff), 32'd16);
        repeat (2) @(negedge clk);
        check("ar decide busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("ar coeff", 32'(scaled_coeff), 32'(INIT_SHIFT));
        check("ar busy",  32'(busy),         32'd0);
        check("ar clip",  32'(clip_flag),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame(32'd0, 8, 5'd8, 1'b0, "ar_after");

`ifdef AGC_MANUAL_OVERRIDE_EN
        do_reset();
        manual_en    = 1'b1;
        manual_shift = 5'd20;
        run_frame(32'h0040_0000, 8, 5'd16, 1'b0, "man20");
        manual_shift = 5'd3;
        run_frame(32'hFFFF_FFFF, 8, 5'd3, 1'b1, "man3a");
        run_frame(32'hFFFF_FFFF, 8, 5'd3, 1'b1, "man3b");
        run_frame(32'd0,         8, 5'd3, 1'b0, "man3c");
        manual_en = 1'b0;
        run_frame(32'd0,         8, 5'd3, 1'b0, "man_release");
`endif

        // Randomized frames against the frame-level model, including abandoned short frames.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [31:0] peak;
            int          len;
            peak = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) peak = 32'd0;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(4, 12));
            model_frame(peak, len, $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
